bin_clock_core: RTL and testbench
=================================

# bin_clock_core

Parametrised binary clock core: keeps hours/minutes/seconds from the system clock through a configurable prescaler. Supports run and set modes, synchronised edge-detected set buttons with increment/decrement, and runtime 12/24-hour display. It is the next-generation timekeeping block, instantiated under the `tt_um_*` top wrapper, which maps its outputs onto `uo_out`/`uio_out` LEDs.

## Interface
- `CLK_DIV`, default 10_000_000: system clock cycles per second; must be ≥2. Benches use small values.
- `SYNC_STAGES`, default 2: flop stages in each button synchroniser; must be ≥2.
- `clk_i` input 1: system clock. One clock domain, rising edge.
- `rstn_i` input 1: reset. Asynchronous assert, active-low.
- `time_set_i` input 1: 1 = set mode, 0 = run mode. Level, synchronised internally.
- `dir_i` input 1: set direction. 1 = increment, 0 = decrement. Sampled synchronised.
- `hour_btn_i` input 1: hour adjust button. Asynchronous, active-high.
- `min_btn_i` input 1: minute adjust button.
- `sec_btn_i` input 1: second adjust button.
- `mode_24h_i` input 1: 1 = 24-hour display, 0 = 12-hour display. Static or slow.
- `hour_o` output 5: displayed hour.
- `min_o` output 6: minutes, 0–59.
- `sec_o` output 6: seconds, 0–59.
- `pm_o` output 1: PM indicator. 12-hour mode only; 0 in 24-hour mode.
- `tick_o` output 1: one-cycle pulse on each run-mode second advance.

## Operation
- **State.** `hour_q` holds 0–23 internally. `min_q` and `sec_q` hold 0–59. Prescaler `div_q` holds 0..CLK_DIV-1.
- **Reset.** All registers clear: time, prescaler, synchronisers, edge-detect history.
  - Outputs at reset: `sec_o`=0, `min_o`=0, `pm_o`=0, `tick_o`=0.
  - `hour_o` at reset = 12 in 12-hour mode, 0 in 24-hour mode.
- **Run mode.**
  - `div_q` increments every cycle and wraps at CLK_DIV-1, asserting the internal second tick.
  - On a tick: `sec_q` increments.
  - 59→0 on `sec_q` carries into `min_q`.
  - 59→0 on `min_q` carries into `hour_q`.
  - 23→0 on `hour_q` wraps; 23:59:59 → 00:00:00.
  - `tick_o` equals the registered tick.
- **Set mode.**
  - `div_q` is held at 0; no ticks; `tick_o`=0.
  - Each button rising edge (post-synchroniser) adjusts only its field by ±1 per `dir_i`.
  - Wrap stays within the field, with no carry: sec 59+1→0, min 0-1→59, hour 23+1→0, hour 0-1→23.
  - Simultaneous edges on several buttons: each field updates independently in the same cycle.
  - A held button gives exactly one adjustment; there is no auto-repeat.
- **Leaving set mode.** Prescaler restarts from 0, so the first tick comes CLK_DIV cycles after the synchronised `time_set_i` falls.
- **Button edges in run mode.** Ignored; the edge history still updates.
- **Display (combinational from state and `mode_24h_i`).**
  - 24-hour mode: `hour_o`=`hour_q`, `pm_o`=0.
  - 12-hour mode: `hour_o` = `hour_q` mod 12, with 0 shown as 12; `pm_o` = (`hour_q` ≥ 12).
  - Toggling `mode_24h_i` changes only the display, never state.
- **Reset mid-operation.** Outputs reach their reset values without a clock edge. Operation resumes in run mode, or in set mode per synchronised `time_set_i`, after release.

## Timing
- **Button latency.** Field changes at the (SYNC_STAGES+1)-th rising edge after the button is first sampled high. With the default, that is 3 edges.
- **Mode latency.** `time_set_i` and `dir_i` have SYNC_STAGES cycles of latency. `dir_i` is sampled in the same cycle as the edge pulse.
- **Tick.** `tick_o` is high for exactly 1 cycle, coincident with the cycle in which the new `sec_o` value first appears.
- **Tick period.** Exactly CLK_DIV cycles between tick pulses in uninterrupted run mode.
- **Output paths.** `hour_o`/`min_o`/`sec_o`/`pm_o` are combinational from registers and `mode_24h_i`. There is no added latency from the state update.

## Structure
- Package `bin_clock_pkg` holds:
  - Field limits `SEC_MAX`=59, `MIN_MAX`=59, `HOUR_MAX`=23, `HOUR12`=12.
  - Field widths: 6, 6, 5.
- Sub-module `bin_clock_btn_sync`:
  - Parameter SYNC_STAGES.
  - SYNC_STAGES-flop synchroniser plus history flop.
  - Outputs a synchronised level and a one-cycle rising-edge pulse.
  - Instantiated 5 times: three buttons (edge used), plus `time_set_i` and `dir_i` (level used).
- Top: prescaler, three field counters with run-carry/set-adjust muxing, and display conversion.

## Test plan
- **Reset values.** CLK_DIV=4, hold reset, `mode_24h_i`=0 → `hour_o`=12, `min_o`=0, `sec_o`=0, `pm_o`=0, `tick_o`=0. Switch to `mode_24h_i`=1 → `hour_o`=0.
- **Run-mode counting.** Release reset in run mode → `tick_o` pulses every 4 cycles. After 240 cycles → `min_o`=1, `sec_o`=0.
- **Day wrap.** In set mode, step to 23:59:59, then enter run mode → 12-hour shows 11:59:59 `pm_o`=1. After the next tick → 12:00:00 `pm_o`=0 (24-hour: 0:00:00).
- **Set-mode wrap without carry.** Set mode, `dir_i`=0, one `min_btn_i` pulse from 00:00:00 → `min_o`=59, `hour_o` unchanged. `dir_i`=1, `sec_btn_i` from sec 59 → `sec_o`=0, `min_o` unchanged.
- **Held and simultaneous buttons.** `hour_btn_i` held 20 cycles → exactly +1 hour, appearing on the 3rd sampling edge. `min_btn_i` and `sec_btn_i` rising together → both fields change in the same cycle.
- **Async reset mid-run.** At 00:01:30, assert `rstn_i` low between clock edges → all outputs at reset values before the next edge. Release → the first tick arrives 4 cycles later.

Source files
------------

// File: rtl/bin_clock_pkg.sv
// Shared field limits, widths and wrap-around step helpers for the binary clock core.
package bin_clock_pkg;

   localparam int SEC_W  = 6;
   localparam int MIN_W  = 6;
   localparam int HOUR_W = 5;

   localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
   localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
   localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
   localparam logic [HOUR_W-1:0] HOUR12   = 5'd12;

   // +/-1 inside [0, max], wrapping at both ends with no carry out.
   function automatic logic [5:0] step6(input logic [5:0] v, input logic [5:0] max, input logic up);
      if (up) step6 = (v == max) ? 6'd0 : v + 6'd1;
      else    step6 = (v == 6'd0) ? max : v - 6'd1;
   endfunction

   function automatic logic [4:0] step5(input logic [4:0] v, input logic [4:0] max, input logic up);
      if (up) step5 = (v == max) ? 5'd0 : v + 5'd1;
      else    step5 = (v == 5'd0) ? max : v - 5'd1;
   endfunction

endpackage

// File: rtl/bin_clock_btn_sync.sv
// Multi-flop synchroniser for one asynchronous input, with a history flop
// producing a one-cycle rising-edge pulse on the synchronised level.
module bin_clock_btn_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic async_i,
   output logic level_o,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/bin_clock_core.sv
// Binary clock core: prescaled seconds/minutes/hours with run-carry counting,
// set-mode per-field button adjust, and 12/24-hour display conversion.
module bin_clock_core
   import bin_clock_pkg::*;
#(
   parameter int CLK_DIV     = 10_000_000,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              time_set_i,
   input  logic              dir_i,
   input  logic              hour_btn_i,
   input  logic              min_btn_i,
   input  logic              sec_btn_i,
   input  logic              mode_24h_i,
   output logic [HOUR_W-1:0] hour_o,
   output logic [MIN_W-1:0]  min_o,
   output logic [SEC_W-1:0]  sec_o,
   output logic              pm_o,
   output logic              tick_o
);

   localparam int               DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic set_lvl, dir_lvl, hour_rise, min_rise, sec_rise;
   logic set_rise, dir_rise, hour_lvl, min_lvl, sec_lvl;
   logic unused_sync;

   bin_clock_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_set_sync (
      .clk_i(clk_i), .rstn_i(rstn_i), .async_i(time_set_i), .level_o(set_lvl), .rise_o(set_rise));
   bin_clock_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dir_sync (
      .clk_i(clk_i), .rstn_i(rstn_i), .async_i(dir_i), .level_o(dir_lvl), .rise_o(dir_rise));
   bin_clock_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_hour_sync (
      .clk_i(clk_i), .rstn_i(rstn_i), .async_i(hour_btn_i), .level_o(hour_lvl), .rise_o(hour_rise));
   bin_clock_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_min_sync (
      .clk_i(clk_i), .rstn_i(rstn_i), .async_i(min_btn_i), .level_o(min_lvl), .rise_o(min_rise));
   bin_clock_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sec_sync (
      .clk_i(clk_i), .rstn_i(rstn_i), .async_i(sec_btn_i), .level_o(sec_lvl), .rise_o(sec_rise));

   assign unused_sync = &{1'b0, set_rise, dir_rise, hour_lvl, min_lvl, sec_lvl};

   logic [DIV_W-1:0]  div_q;
   logic              tick_q;
   logic [HOUR_W-1:0] hour_q;
   logic [MIN_W-1:0]  min_q;
   logic [SEC_W-1:0]  sec_q;
   logic              run_tick;

   assign run_tick = ~set_lvl & (div_q == DIV_LAST);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         div_q  <= '0;
         tick_q <= 1'b0;
         hour_q <= '0;
         min_q  <= '0;
         sec_q  <= '0;
      end else if (set_lvl) begin
         // Prescaler parked at 0 so the first run tick lands CLK_DIV cycles after leaving set mode.
         div_q  <= '0;
         tick_q <= 1'b0;
         if (hour_rise) hour_q <= step5(hour_q, HOUR_MAX, dir_lvl);
         if (min_rise)  min_q  <= step6(min_q, MIN_MAX, dir_lvl);
         if (sec_rise)  sec_q  <= step6(sec_q, SEC_MAX, dir_lvl);
      end else begin
         tick_q <= run_tick;
         if (run_tick) begin
            div_q <= '0;
            sec_q <= step6(sec_q, SEC_MAX, 1'b1);
            if (sec_q == SEC_MAX) begin
               min_q <= step6(min_q, MIN_MAX, 1'b1);
               if (min_q == MIN_MAX) hour_q <= step5(hour_q, HOUR_MAX, 1'b1);
            end
         end else begin
            div_q <= div_q + 1'b1;
         end
      end
   end

   always_comb begin
      hour_o = hour_q;
      pm_o   = 1'b0;
      if (!mode_24h_i) begin
         pm_o = (hour_q >= HOUR12);
         if (hour_q == '0)        hour_o = HOUR12;
         else if (hour_q > HOUR12) hour_o = hour_q - HOUR12;
      end
   end

   assign min_o  = min_q;
   assign sec_o  = sec_q;
   assign tick_o = tick_q;

endmodule

// File: tb/tb_bin_clock_core.sv
// Directed bench for bin_clock_core with CLK_DIV=4 and two-stage synchronisers.
module tb_bin_clock_core;

   localparam int CLK_DIV     = 4;
   localparam int SYNC_STAGES = 2;

   logic       clk = 1'b0;
   logic       rstn_i = 1'b0;
   logic       time_set_i = 1'b0;
   logic       dir_i = 1'b1;
   logic       hour_btn_i = 1'b0;
   logic       min_btn_i = 1'b0;
   logic       sec_btn_i = 1'b0;
   logic       mode_24h_i = 1'b0;
   logic [4:0] hour_o;
   logic [5:0] min_o;
   logic [5:0] sec_o;
   logic       pm_o;
   logic       tick_o;

   int checks = 0;
   int errors = 0;

   bin_clock_core #(.CLK_DIV(CLK_DIV), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk_i(clk), .rstn_i(rstn_i), .time_set_i(time_set_i), .dir_i(dir_i),
      .hour_btn_i(hour_btn_i), .min_btn_i(min_btn_i), .sec_btn_i(sec_btn_i),
      .mode_24h_i(mode_24h_i), .hour_o(hour_o), .min_o(min_o), .sec_o(sec_o),
      .pm_o(pm_o), .tick_o(tick_o));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance n rising edges, landing 1 time unit after the last one.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reset with time_set_i high, then let the synchroniser settle into set mode at 00:00:00.
   task automatic enter_set();
      rstn_i = 1'b0;
      time_set_i = 1'b1;
      hour_btn_i = 1'b0; min_btn_i = 1'b0; sec_btn_i = 1'b0;
      cyc(1);
      rstn_i = 1'b1;
      cyc(3);
   endtask

   task automatic press(input logic d, input logic h, input logic m, input logic s);
      dir_i = d;
      cyc(3);
      hour_btn_i = h; min_btn_i = m; sec_btn_i = s;
      cyc(4);
      hour_btn_i = 1'b0; min_btn_i = 1'b0; sec_btn_i = 1'b0;
      cyc(3);
   endtask

   task automatic test_reset();
      rstn_i = 1'b0;
      mode_24h_i = 1'b0;
      cyc(3);
      checks++;
      if ({hour_o, min_o, sec_o, pm_o, tick_o} !== {5'd12, 6'd0, 6'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_12h got %0d:%0d:%0d pm=%0d tick=%0d exp 12:0:0 pm=0 tick=0",
                  hour_o, min_o, sec_o, pm_o, tick_o);
      end
      mode_24h_i = 1'b1;
      #1;
      checks++;
      if (hour_o !== 5'd0) begin
         errors++;
         $display("FAIL reset_24h_hour got %0d exp 0", hour_o);
      end
      mode_24h_i = 1'b0;
      #1;
   endtask

   task automatic test_run_counting();
      logic exp_tick;
      @(posedge clk);
      #1;
      rstn_i = 1'b1;
      for (int c = 1; c <= 240; c++) begin
         cyc(1);
         exp_tick = ((c % 4) == 0);
         checks++;
         if (tick_o !== exp_tick) begin
            errors++;
            $display("FAIL run_tick cycle %0d got %0d exp %0d", c, tick_o, exp_tick);
         end
         if (c == 4) begin
            checks++;
            if (sec_o !== 6'd1) begin
               errors++;
               $display("FAIL run_first_sec got %0d exp 1", sec_o);
            end
         end
      end
      checks++;
      if ({hour_o, min_o, sec_o} !== {5'd12, 6'd1, 6'd0}) begin
         errors++;
         $display("FAIL run_240 got %0d:%0d:%0d exp 12:1:0", hour_o, min_o, sec_o);
      end
   endtask

   task automatic test_day_wrap();
      logic exp_tick;
      enter_set();
      press(1'b0, 1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b0, 1'b1, 1'b0);
      press(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({hour_o, min_o, sec_o, pm_o} !== {5'd11, 6'd59, 6'd59, 1'b1}) begin
         errors++;
         $display("FAIL day_wrap_set got %0d:%0d:%0d pm=%0d exp 11:59:59 pm=1", hour_o, min_o, sec_o, pm_o);
      end
      time_set_i = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         cyc(1);
         exp_tick = (c == 6);
         checks++;
         if (tick_o !== exp_tick) begin
            errors++;
            $display("FAIL leave_set_tick cycle %0d got %0d exp %0d", c, tick_o, exp_tick);
         end
         if (c == 5) begin
            checks++;
            if ({hour_o, min_o, sec_o, pm_o} !== {5'd11, 6'd59, 6'd59, 1'b1}) begin
               errors++;
               $display("FAIL day_wrap_pre got %0d:%0d:%0d pm=%0d exp 11:59:59 pm=1", hour_o, min_o, sec_o, pm_o);
            end
         end
      end
      checks++;
      if ({hour_o, min_o, sec_o, pm_o} !== {5'd12, 6'd0, 6'd0, 1'b0}) begin
         errors++;
         $display("FAIL day_wrap_12h got %0d:%0d:%0d pm=%0d exp 12:0:0 pm=0", hour_o, min_o, sec_o, pm_o);
      end
      mode_24h_i = 1'b1;
      #1;
      checks++;
      if ({hour_o, min_o, sec_o, pm_o} !== {5'd0, 6'd0, 6'd0, 1'b0}) begin
         errors++;
         $display("FAIL day_wrap_24h got %0d:%0d:%0d pm=%0d exp 0:0:0 pm=0", hour_o, min_o, sec_o, pm_o);
      end
      mode_24h_i = 1'b0;
      #1;
   endtask

   task automatic test_set_wrap();
      enter_set();
      press(1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({hour_o, min_o, sec_o} !== {5'd12, 6'd59, 6'd0}) begin
         errors++;
         $display("FAIL set_min_dec_wrap got %0d:%0d:%0d exp 12:59:0", hour_o, min_o, sec_o);
      end
      press(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({hour_o, min_o, sec_o} !== {5'd12, 6'd59, 6'd59}) begin
         errors++;
         $display("FAIL set_sec_dec_wrap got %0d:%0d:%0d exp 12:59:59", hour_o, min_o, sec_o);
      end
      press(1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({hour_o, min_o, sec_o, tick_o} !== {5'd12, 6'd59, 6'd0, 1'b0}) begin
         errors++;
         $display("FAIL set_sec_inc_wrap got %0d:%0d:%0d tick=%0d exp 12:59:0 tick=0", hour_o, min_o, sec_o, tick_o);
      end
   endtask

   task automatic test_held_and_simultaneous();
      logic [4:0] exp_hour;
      dir_i = 1'b1;
      cyc(3);
      hour_btn_i = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         cyc(1);
         exp_hour = (c >= 3) ? 5'd1 : 5'd12;
         checks++;
         if (hour_o !== exp_hour) begin
            errors++;
            $display("FAIL held_hour cycle %0d got %0d exp %0d", c, hour_o, exp_hour);
         end
      end
      hour_btn_i = 1'b0;
      cyc(4);
      min_btn_i = 1'b1;
      sec_btn_i = 1'b1;
      cyc(2);
      checks++;
      if ({min_o, sec_o} !== {6'd59, 6'd0}) begin
         errors++;
         $display("FAIL simul_before got %0d:%0d exp 59:0", min_o, sec_o);
      end
      cyc(1);
      checks++;
      if ({hour_o, min_o, sec_o} !== {5'd1, 6'd0, 6'd1}) begin
         errors++;
         $display("FAIL simul_after got %0d:%0d:%0d exp 1:0:1", hour_o, min_o, sec_o);
      end
      min_btn_i = 1'b0;
      sec_btn_i = 1'b0;
      cyc(3);
   endtask

   task automatic test_async_reset();
      logic exp_tick;
      rstn_i = 1'b0;
      time_set_i = 1'b0;
      cyc(1);
      rstn_i = 1'b1;
      cyc(360);
      checks++;
      if ({hour_o, min_o, sec_o, tick_o} !== {5'd12, 6'd1, 6'd30, 1'b1}) begin
         errors++;
         $display("FAIL run_to_0130 got %0d:%0d:%0d tick=%0d exp 12:1:30 tick=1", hour_o, min_o, sec_o, tick_o);
      end
      #2;
      rstn_i = 1'b0;
      #1;
      checks++;
      if ({hour_o, min_o, sec_o, pm_o, tick_o} !== {5'd12, 6'd0, 6'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset got %0d:%0d:%0d pm=%0d tick=%0d exp 12:0:0 pm=0 tick=0",
                  hour_o, min_o, sec_o, pm_o, tick_o);
      end
      cyc(1);
      rstn_i = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         cyc(1);
         exp_tick = (c == 4);
         checks++;
         if (tick_o !== exp_tick) begin
            errors++;
            $display("FAIL post_reset_tick cycle %0d got %0d exp %0d", c, tick_o, exp_tick);
         end
      end
      checks++;
      if (sec_o !== 6'd1) begin
         errors++;
         $display("FAIL post_reset_sec got %0d exp 1", sec_o);
      end
   endtask

   initial begin
      test_reset();
      test_run_counting();
      test_day_wrap();
      test_set_wrap();
      test_held_and_simultaneous();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
